aes_job_scheduler: RTL

- Shares one AES encrypt/decrypt datapath between two requesters (round-robin arbitration); one job in flight at a time.
- The datapath is external (enc/dec core, combinational or fixed-latency); this block registers its inputs, waits a fixed latency, captures its output and returns the result with a requester ID.
- Sits between the system bus agents and the AES core.

---
 rtl/aes_job_scheduler_if.sv | 49 ++++
 rtl/aes_job_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/aes_job_scheduler_if.sv
// Bus bundle for the AES job scheduler: two requester ports, the
// core-facing block/mode/result signals and the response/status outputs.
interface aes_job_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [127:0]     req0_data;
  logic             req0_dec;

  logic             req1_valid;
  logic             req1_ready;
  logic [127:0]     req1_data;
  logic             req1_dec;

  logic [127:0]     core_data;
  logic             core_dec;
  logic [127:0]     core_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [127:0]     rsp_data;
  logic             rsp_id;

  logic             busy;
  logic [CNT_W-1:0] done_count;

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_data, req0_dec,
    input  req1_valid, req1_data, req1_dec,
    input  core_result, rsp_ready,
    output req0_ready, req1_ready,
    output core_data, core_dec,
    output rsp_valid, rsp_data, rsp_id,
    output busy, done_count
  );

  // Environment side: requesters, AES core and response consumer.
  modport master (
    output req0_valid, req0_data, req0_dec,
    output req1_valid, req1_data, req1_dec,
    output core_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  core_data, core_dec,
    input  rsp_valid, rsp_data, rsp_id,
    input  busy, done_count
  );
endinterface

// File: rtl/aes_job_scheduler.sv
// Shares one external AES enc/dec datapath between two requesters.
// Round-robin grant in IDLE, registered core inputs, fixed-latency wait,
// captured result held until the consumer takes it. One job in flight.
module aes_job_scheduler #(
  parameter int CORE_LAT = 1,   // 1..15 cycles from core input change to valid result
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_job_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAT = 4'(CORE_LAT);

  state_t           r_state;
  state_t           w_state_next;

  logic             r_last_grant;   // requester granted most recently
  logic [3:0]       r_wait_cnt;
  logic [127:0]     r_core_data;
  logic             r_core_dec;
  logic             r_rsp_valid;
  logic [127:0]     r_rsp_data;
  logic             r_rsp_id;
  logic [CNT_W-1:0] r_done_count;

  logic             w_grant;
  logic             w_any_valid;
  logic             w_handshake;
  logic             w_wait_last;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    w_any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = bus.req1_valid;
    end
    w_handshake = (r_state == IDLE) && w_any_valid;
    w_wait_last = (r_wait_cnt == 4'd1);
  end

  // Ready is only ever raised for the granted requester while idle.
  assign bus.req0_ready = (r_state == IDLE) && !w_grant && bus.req0_valid;
  assign bus.req1_ready = (r_state == IDLE) &&  w_grant && bus.req1_valid;

  assign bus.core_data  = r_core_data;
  assign bus.core_dec   = r_core_dec;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done_count = r_done_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (w_wait_last) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Job datapath: latch the granted request, count down the core latency,
  // capture the result and count completed jobs. A reset mid-job simply
  // drops everything, so the aborted job is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;          // makes requester 0 win the first tie
      r_wait_cnt   <= 4'd0;
      r_core_data  <= '0;
      r_core_dec   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_done_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_handshake) begin
            r_core_data  <= w_grant ? bus.req1_data : bus.req0_data;
            r_core_dec   <= w_grant ? bus.req1_dec  : bus.req0_dec;
            r_rsp_id     <= w_grant;
            r_last_grant <= w_grant;
            r_wait_cnt   <= LP_LAT;
          end
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (w_wait_last) begin
            r_rsp_data  <= bus.core_result;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_done_count <= r_done_count + CNT_W'(1);
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
